// File: rtl/press_pkg.sv
// ============================================================================
// Module   : press_pkg
// Brief    : Shared state encoding and 25 MHz default limits for press_classifier.
// Revision : 1.0
// ============================================================================
`default_nettype none

package press_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_HELD         = 2'd1,
        ST_GAP          = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } state_t;

    // 1 s hold and 300 ms release gap at 25 MHz
    localparam int c_LONG_PRESS_LIMIT = 25_000_000;
    localparam int c_DOUBLE_GAP_LIMIT = 7_500_000;

    function automatic int press_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/press_classifier.sv
// ============================================================================
// Module   : press_classifier
// Brief    : Classifies a debounced switch level into short/long/double press
//            pulses. Macro PRESS_DOUBLE_EN enables double-press detection.
// Revision : 1.0
// ============================================================================
`default_nettype none

module press_classifier #(
    parameter int LONG_PRESS_LIMIT = press_pkg::c_LONG_PRESS_LIMIT,
    parameter int DOUBLE_GAP_LIMIT = press_pkg::c_DOUBLE_GAP_LIMIT
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Debounced,
    output logic o_Pressed,
    output logic o_Short_Press,
    output logic o_Long_Press,
    output logic o_Double_Press
);

    import press_pkg::*;

    localparam int CNT_WIDTH = $clog2(press_max(LONG_PRESS_LIMIT, DOUBLE_GAP_LIMIT) + 1);

    localparam logic [CNT_WIDTH-1:0] c_LONG_LAST = CNT_WIDTH'(LONG_PRESS_LIMIT - 1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX   = {CNT_WIDTH{1'b1}};
`ifdef PRESS_DOUBLE_EN
    localparam logic [CNT_WIDTH-1:0] c_GAP_LAST  = CNT_WIDTH'(DOUBLE_GAP_LIMIT - 1);
`endif

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   w_cnt_next;
    logic                   w_short;
    logic                   w_long;
    logic                   w_double;

    // Reset parks in WAIT_RELEASE so a switch held through reset stays silent
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state        <= ST_WAIT_RELEASE;
            r_cnt          <= '0;
            o_Pressed      <= 1'b0;
            o_Short_Press  <= 1'b0;
            o_Long_Press   <= 1'b0;
            o_Double_Press <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_cnt          <= w_cnt_next;
            o_Pressed      <= i_Debounced;
            o_Short_Press  <= w_short;
            o_Long_Press   <= w_long;
            o_Double_Press <= w_double;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_short      = 1'b0;
        w_long       = 1'b0;
        w_double     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_Debounced) begin
                    w_next_state = ST_HELD;
                    w_cnt_next   = '0;
                end
            end

            ST_HELD: begin
                // A release on the limit edge takes priority over the long press
                if (i_Debounced) begin
                    if (r_cnt == c_LONG_LAST) begin
                        w_long       = 1'b1;
                        w_next_state = ST_WAIT_RELEASE;
                    end else if (r_cnt != c_CNT_MAX) begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end else begin
`ifdef PRESS_DOUBLE_EN
                    w_next_state = ST_GAP;
                    w_cnt_next   = '0;
`else
                    w_short      = 1'b1;
                    w_next_state = ST_IDLE;
`endif
                end
            end

`ifdef PRESS_DOUBLE_EN
            ST_GAP: begin
                // A second press on the limit edge still counts as a double
                if (i_Debounced) begin
                    w_double     = 1'b1;
                    w_next_state = ST_WAIT_RELEASE;
                end else if (r_cnt == c_GAP_LAST) begin
                    w_short      = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (r_cnt != c_CNT_MAX) begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
`endif

            ST_WAIT_RELEASE: begin
                if (!i_Debounced) begin
                    w_next_state = ST_IDLE;
                end
            end

            default: begin
                w_next_state = ST_WAIT_RELEASE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_press_classifier.sv
// ============================================================================
// Module   : tb_press_classifier
// Brief    : Directed, table-driven bench for press_classifier (LONG=10, GAP=6);
//            expectations follow the PRESS_DOUBLE_EN build selection.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_press_classifier;
    import press_pkg::*;

    localparam logic [2:0] EV_NONE = 3'b000;
    localparam logic [2:0] EV_S    = 3'b001;
    localparam logic [2:0] EV_L    = 3'b010;
    localparam logic [2:0] EV_D    = 3'b100;

    typedef struct packed {
        logic       rst;
        logic       din;
        logic [2:0] ev;     // {double, long, short} expected after the edge
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic pressed, short_p, long_p, double_p;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    press_classifier #(
        .LONG_PRESS_LIMIT (10),
        .DOUBLE_GAP_LIMIT (6)
    ) dut (
        .i_Clk          (clk),
        .i_Rst          (rst),
        .i_Debounced    (din),
        .o_Pressed      (pressed),
        .o_Short_Press  (short_p),
        .o_Long_Press   (long_p),
        .o_Double_Press (double_p)
    );

    task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %b, expected %b", name, idx, act, exp);
        end
    endtask

    task automatic tick(input logic r, input logic d);
        rst = r;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic d, input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.rst = r; v.din = d; v.ev = EV_NONE;
            vecs.push_back(v);
        end
    endtask

    task automatic add_ev(input logic d, input logic [2:0] ev);
        vec_t v;
        v.rst = 1'b0; v.din = d; v.ev = ev;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1;
        din = 1'b1;

        // Switch held through reset: silent, then IDLE one edge after release
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1);
            check("reset_outputs", i, {pressed, double_p, long_p, short_p}, 4'b0000);
        end
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b1);
            check("held_after_reset", i, {pressed, double_p, long_p, short_p}, 4'b1000);
        end
        check("state_wait_release", 0, {2'b00, dut.r_state}, {2'b00, ST_WAIT_RELEASE});
        tick(1'b0, 1'b0);
        check("state_idle_after_release", 0, {2'b00, dut.r_state}, {2'b00, ST_IDLE});
        check("release_no_event", 0, {pressed, double_p, long_p, short_p}, 4'b0000);
        add(0, 0, 2);

`ifdef PRESS_DOUBLE_EN
        // Short press: event 6 edges after GAP entry
        add(0, 1, 4); add(0, 0, 1); add(0, 0, 5); add_ev(0, EV_S); add(0, 0, 3);
`else
        add(0, 1, 4); add_ev(0, EV_S); add(0, 0, 3);
`endif
        // Long press: 10 edges after HELD entry, release is silent
        add(0, 1, 10); add_ev(1, EV_L); add(0, 1, 4); add(0, 0, 3);

`ifdef PRESS_DOUBLE_EN
        // Double press on second rise
        add(0, 1, 3); add(0, 0, 2); add_ev(1, EV_D); add(0, 1, 2); add(0, 0, 3);
        // Release on 10th held edge: no long, short follows
        add(0, 1, 10); add(0, 0, 1); add(0, 0, 5); add_ev(0, EV_S); add(0, 0, 2);
        // Second press on 6th gap edge: double wins
        add(0, 1, 2); add(0, 0, 1); add(0, 0, 5); add_ev(1, EV_D); add(0, 1, 2); add(0, 0, 2);
        // Third press held long after a double: absorbed
        add(0, 1, 2); add(0, 0, 1); add_ev(1, EV_D); add(0, 1, 12); add(0, 0, 2);
        // Reset while in GAP: pending short dropped
        add(0, 1, 3); add(0, 0, 3); add(1, 0, 1); add(0, 0, 8);
`else
        // Two presses: each short, never double
        add(0, 1, 3); add_ev(0, EV_S); add(0, 0, 1); add(0, 1, 3); add_ev(0, EV_S); add(0, 0, 2);
        // Release on 10th held edge: short, no long
        add(0, 1, 10); add_ev(0, EV_S); add(0, 0, 2);
        // Second press after short gap: two shorts
        add(0, 1, 2); add_ev(0, EV_S); add(0, 0, 5); add(0, 1, 3); add_ev(0, EV_S); add(0, 0, 2);
`endif
        // Reset on the release edge drops the short press
        add(0, 1, 3); add(1, 0, 1); add(0, 0, 3);
        // Reset mid-hold: switch still held afterwards stays silent
        add(0, 1, 5); add(1, 1, 1); add(0, 1, 12); add(0, 0, 2);
        // Fresh short press after all of the above
`ifdef PRESS_DOUBLE_EN
        add(0, 1, 1); add(0, 0, 1); add(0, 0, 5); add_ev(0, EV_S); add(0, 0, 2);
`else
        add(0, 1, 1); add_ev(0, EV_S); add(0, 0, 2);
`endif

        foreach (vecs[i]) begin
            tick(vecs[i].rst, vecs[i].din);
            check("pressed", i, {3'b000, pressed}, {3'b000, vecs[i].rst ? 1'b0 : vecs[i].din});
            check("events", i, {1'b0, double_p, long_p, short_p}, {1'b0, vecs[i].ev});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/press_classifier.md
Name: press_classifier

Overview:
- Downstream consumer of the debounce filter output; replaces simple toggling with press-gesture classification.
- Takes the clean, clock-synchronous switch level and emits one-cycle event pulses for short press, long press and double press.
- Pulses feed LED/seven-segment control logic on the Go Board (25 MHz clock).

Parameters:
- LONG_PRESS_LIMIT, 25000000, cycles the switch must stay held to count as a long press (1 s).
- DOUBLE_GAP_LIMIT, 7500000, maximum released cycles between two presses for a double press (300 ms).
- CNT_WIDTH, $clog2 of max(LONG_PRESS_LIMIT, DOUBLE_GAP_LIMIT)+1, shared counter width; derived, not overridden.

Ports:
- i_Clk  input  1  system clock.
- i_Rst  input  1  reset; synchronous, active-high.
- i_Debounced  input  1  debounced switch level, 1 = pressed; already synchronous to i_Clk.
- o_Pressed  output  1  registered copy of i_Debounced.
- o_Short_Press  output  1  one-cycle pulse when a single short press is classified.
- o_Long_Press  output  1  one-cycle pulse when the hold time reaches LONG_PRESS_LIMIT.
- o_Double_Press  output  1  one-cycle pulse on the second press of a double press.

Behaviour:
- Reset: all outputs 0, counter 0, state WAIT_RELEASE. A switch held through reset generates no event.
- All outputs are registered. Event pulses are exactly one cycle wide and mutually exclusive.
- States and transitions, evaluated each clock edge:
  - IDLE: if i_Debounced=1, go to HELD and clear the counter.
  - HELD, input high: increment the counter. On the edge where the counter equals LONG_PRESS_LIMIT-1, pulse o_Long_Press and go to WAIT_RELEASE. The pulse is therefore registered LONG_PRESS_LIMIT edges after HELD entry.
  - HELD, input low: clear the counter and go to GAP.
  - GAP, input high: pulse o_Double_Press (same edge) and go to WAIT_RELEASE.
  - GAP, input low: increment the counter. On the edge where the counter equals DOUBLE_GAP_LIMIT-1, pulse o_Short_Press and go to IDLE.
  - WAIT_RELEASE: if i_Debounced=0, go to IDLE. No events are generated in this state.
- Simultaneous events:
  - If the input falls on the edge where HELD reaches the limit, the release wins: go to GAP, no long press.
  - If the input rises on the edge where GAP reaches the limit, the press wins: double press, no short press.
- A third press after a double press is not a new gesture until release: WAIT_RELEASE absorbs it.
- Counter saturates and never wraps; it is cleared on every state entry that uses it.
- i_Rst asserted mid-gesture: state, counter and outputs return to reset values on that edge, and any pending event is dropped.

Optional Feature:
- Macro: PRESS_DOUBLE_EN.
- Defined: behaviour exactly as above.
- Not defined:
  - GAP state is removed and o_Double_Press is tied to 0.
  - HELD with input low pulses o_Short_Press on that same edge and goes to IDLE; short-press latency is 0 cycles after the release is sampled.
  - DOUBLE_GAP_LIMIT is ignored.

Decomposition:
- Shared package press_pkg holds:
  - state encoding localparams ST_IDLE=0, ST_HELD=1, ST_GAP=2, ST_WAIT_RELEASE=3 (2-bit);
  - default limit constants for 25 MHz.
- No sub-module; the FSM and the single shared counter stay inline (target ~150 lines).
- Top-level integration instantiates debounce_filter followed by press_classifier.

Test Plan:
- Use LONG_PRESS_LIMIT=10, DOUBLE_GAP_LIMIT=6 for all scenarios.
- Reset scenario: i_Debounced=1 throughout reset and for 20 cycles after, then 0 -> no pulses at all; state reaches IDLE one cycle after release.
- Short press: high 4 cycles, then low -> o_Short_Press exactly 6 cycles after the GAP entry edge, once; no other pulses.
- Long press: high 15 cycles -> o_Long_Press one cycle wide, 10 edges after HELD entry; no pulse on the later release.
- Double press: high 3, low 2, high 3, low -> o_Double_Press on the edge the second rise is sampled; no o_Short_Press.
- Boundary cases:
  - Release exactly on the 10th held edge -> no long press; a short press follows.
  - Second press exactly on the 6th gap edge -> double press, not short press.
- Reset mid-operation: i_Rst pulsed while in GAP -> no o_Short_Press; all outputs 0 the next cycle. With PRESS_DOUBLE_EN undefined: high 3, low -> o_Short_Press on the release edge, and o_Double_Press never asserts.
